sram_wait_state_gen: RTL and testbench

Parametrised SRAM wait-state generator for the bus-side memory model. It watches the chip-enable, write-enable and address of the attached SRAM and returns a one-cycle `ready` pulse a fixed, per-direction number of cycles after each qualifying access. It replaces the fixed two-cycle ready generator. New behaviour: separate read and write latencies, a correct first access to address 0, a `busy` indicator, and optional back-to-back accesses.

---
 rtl/sram_wait_pkg.sv | 21 ++
 rtl/sram_latency_counter.sv | 44 ++++
 rtl/sram_wait_state_gen.sv | 133 +++++++++++++
 tb/tb_sram_wait_state_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_wait_pkg.sv
// sram_wait_pkg: shared types and helpers for the SRAM wait-state generator.
//   state_e      - FSM state encoding (idle / counting / ready pulse)
//   sel_latency  - picks the per-direction access latency
package sram_wait_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StDone = 2'b10
    } state_e;

    // Latency in cycles from request acceptance to the ready pulse.
    function automatic int unsigned sel_latency(
        input logic        wen,
        input int unsigned rd_latency,
        input int unsigned wr_latency
    );
        return wen ? wr_latency : rd_latency;
    endfunction

endpackage

// File: rtl/sram_latency_counter.sv
// sram_latency_counter: loadable down-counter timing the WAIT phase.
// Ports:
//   clk, rst    - clock (rising edge), asynchronous active-high reset
//   load        - load load_value (takes priority over dec)
//   load_value  - value to load
//   dec         - decrement by one
//   value       - current count
//   zero        - count is zero
module sram_latency_counter #(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (dec) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/sram_wait_state_gen.sv
// sram_wait_state_gen: returns a registered one-cycle ready pulse a fixed,
// per-direction number of cycles after each qualifying SRAM access.
// A request qualifies when cen is high and the address differs from the last
// accepted one, or it is a write, or nothing has been accepted since reset.
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   cen       - chip enable
//   wen       - 1 = write, 0 = read (sampled on accept)
//   address   - SRAM address
//   ready     - access complete, one-cycle pulse
//   busy      - access in flight
// Parameters: ADDR_WIDTH, RD_LATENCY (>= 1), WR_LATENCY (>= 1),
//   CNT_WIDTH (must hold max(RD_LATENCY, WR_LATENCY)).
// Build option: define SRAM_WAIT_BACK2BACK_EN to accept a new qualifying
//   request in the DONE cycle instead of returning to IDLE first.
module sram_wait_state_gen
    import sram_wait_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned WR_LATENCY = 1,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic                  ready,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  seen_q, seen_d;
    logic                  ready_q, ready_d;

    logic                  req_ok;
    logic                  accept;
    int unsigned           lat;
    logic                  lat_is_one;
    logic [CNT_WIDTH-1:0]  lat_load;

    logic                  cnt_load;
    logic                  cnt_dec;
    logic [CNT_WIDTH-1:0]  cnt_value;
    logic                  cnt_zero;

    // The seen flag lets the very first access after reset qualify even at
    // address 0, which matches the reset value of last_addr.
    assign req_ok     = cen && ((address != last_addr_q) || wen || !seen_q);
    assign lat        = sel_latency(wen, RD_LATENCY, WR_LATENCY);
    assign lat_is_one = (lat <= 1);
    // One cycle of the latency is spent in DONE and one entering WAIT.
    assign lat_load   = lat_is_one ? '0 : CNT_WIDTH'(lat - 2);

    sram_latency_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (lat_load),
        .dec        (cnt_dec),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        seen_d      = seen_q;
        accept      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = req_ok;
            end
            StWait: begin
                if (cnt_zero) begin
                    state_d = StDone;
                end
                // Never wrap below zero.
                cnt_dec = (cnt_value != '0);
            end
            StDone: begin
`ifdef SRAM_WAIT_BACK2BACK_EN
                state_d = StIdle;
                accept  = req_ok;
`else
                state_d = StIdle;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            last_addr_d = address;
            seen_d      = 1'b1;
            if (lat_is_one) begin
                state_d = StDone;
            end else begin
                state_d  = StWait;
                cnt_load = 1'b1;
            end
        end
    end

    // Registered ready: high exactly in the cycles the FSM sits in DONE.
    assign ready_d = (state_d == StDone);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            last_addr_q <= '0;
            seen_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            seen_q      <= seen_d;
            ready_q     <= ready_d;
        end
    end

    assign ready = ready_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_sram_wait_state_gen.sv
// Bench for sram_wait_state_gen: one instance with default latencies
// (read 2, write 1) and one with read latency 4. Stimulus pushes the absolute
// cycle in which ready must pulse; per-instance monitors pop and compare.
module tb_sram_wait_state_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        rst_a, cen_a, wen_a, ready_a, busy_a;
    logic [11:0] addr_a;
    logic        rst_b, cen_b, wen_b, ready_b, busy_b;
    logic [11:0] addr_b;

    int q_a[$];
    int q_b[$];
    int t;

    sram_wait_state_gen dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .cen     (cen_a),
        .wen     (wen_a),
        .address (addr_a),
        .ready   (ready_a),
        .busy    (busy_a)
    );

    sram_wait_state_gen #(
        .ADDR_WIDTH (12),
        .RD_LATENCY (4),
        .WR_LATENCY (1),
        .CNT_WIDTH  (4)
    ) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .cen     (cen_b),
        .wen     (wen_b),
        .address (addr_b),
        .ready   (ready_b),
        .busy    (busy_b)
    );

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q_a.size() > 0 && q_a[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL ready_a missed: got no pulse, expected cycle %0d", q_a[0]);
            void'(q_a.pop_front());
        end
        if (ready_a === 1'b1) begin
            if (q_a.size() > 0) begin
                check("ready_a cycle", cyc, q_a.pop_front());
            end else begin
                total++;
                bad++;
                $display("FAIL ready_a unexpected: got pulse at cycle %0d, expected none", cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (q_b.size() > 0 && q_b[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL ready_b missed: got no pulse, expected cycle %0d", q_b[0]);
            void'(q_b.pop_front());
        end
        if (ready_b === 1'b1) begin
            if (q_b.size() > 0) begin
                check("ready_b cycle", cyc, q_b.pop_front());
            end else begin
                total++;
                bad++;
                $display("FAIL ready_b unexpected: got pulse at cycle %0d, expected none", cyc);
            end
        end
    end

    initial begin
        rst_a = 1'b1; cen_a = 1'b0; wen_a = 1'b0; addr_a = 12'h000;
        rst_b = 1'b1; cen_b = 1'b0; wen_b = 1'b0; addr_b = 12'h000;
        repeat (3) tick();
        check("reset ready_a", int'(ready_a), 0);
        check("reset busy_a", int'(busy_a), 0);
        check("reset ready_b", int'(ready_b), 0);
        check("reset busy_b", int'(busy_b), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // First read at address 0 after reset must qualify.
        t = cyc;
        cen_a = 1'b1; wen_a = 1'b0; addr_a = 12'h000;
        q_a.push_back(t + 2);
        tick();
        cen_a = 1'b0;
        check("busy_a read0 t+1", int'(busy_a), 1);
        tick();
        check("busy_a read0 t+2", int'(busy_a), 1);
        tick();
        check("busy_a read0 t+3", int'(busy_a), 0);

        // Read held at the same address: one pulse only.
        t = cyc;
        cen_a = 1'b1; wen_a = 1'b0; addr_a = 12'h010;
        q_a.push_back(t + 2);
        repeat (5) tick();
        cen_a = 1'b0;
        tick();

        // Write held for six cycles.
        t = cyc;
        cen_a = 1'b1; wen_a = 1'b1; addr_a = 12'h010;
`ifdef SRAM_WAIT_BACK2BACK_EN
        for (int i = 1; i <= 6; i++) q_a.push_back(t + i);
`else
        q_a.push_back(t + 1);
        q_a.push_back(t + 3);
        q_a.push_back(t + 5);
`endif
        repeat (6) tick();
        cen_a = 1'b0; wen_a = 1'b0;
        repeat (2) tick();

        // Inputs change mid-access; access completes and last_addr keeps 0x030.
        t = cyc;
        cen_a = 1'b1; wen_a = 1'b0; addr_a = 12'h030;
        q_a.push_back(t + 2);
        tick();
        cen_a = 1'b0; addr_a = 12'h031;
        repeat (2) tick();
        check("busy_a after 0x030", int'(busy_a), 0);
        cen_a = 1'b1; addr_a = 12'h030;
        repeat (3) tick();
        check("busy_a repeat 0x030", int'(busy_a), 0);
        cen_a = 1'b0;
        tick();
        t = cyc;
        cen_a = 1'b1; addr_a = 12'h031;
        q_a.push_back(t + 2);
        tick();
        cen_a = 1'b0;
        repeat (3) tick();

        // Reset mid-access on the latency-4 instance.
        t = cyc;
        cen_b = 1'b1; wen_b = 1'b0; addr_b = 12'h020;
        tick();
        cen_b = 1'b0;
        tick();
        rst_b = 1'b1;
        #1;
        check("rst ready_b", int'(ready_b), 0);
        check("rst busy_b", int'(busy_b), 0);
        repeat (2) tick();
        rst_b = 1'b0;
        tick();
        t = cyc;
        cen_b = 1'b1; addr_b = 12'h020;
        q_b.push_back(t + 4);
        tick();
        cen_b = 1'b0;
        check("busy_b t+1", int'(busy_b), 1);
        repeat (5) tick();

        // After another reset, address 0 must qualify again.
        rst_b = 1'b1;
        repeat (2) tick();
        rst_b = 1'b0;
        tick();
        t = cyc;
        cen_b = 1'b1; addr_b = 12'h000;
        q_b.push_back(t + 4);
        tick();
        cen_b = 1'b0;
        repeat (6) tick();

        check("q_a drained", q_a.size(), 0);
        check("q_b drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
